// File: rtl/timer_8bit.sv
// Memory-mapped 8-bit down-counting timer with prescaler, auto-reload,
// level interrupt and a square-wave output that toggles on each underflow.
module timer_8bit #(
  parameter int PRESCALE_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chip_select,
  input  logic       write_enable,
  input  logic [1:0] addr_sel,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq,
  output logic       tmr_out
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic                  r_en;
  logic                  r_auto;
  logic                  r_irq_en;
  logic [1:0]            r_psel;
  logic [7:0]            r_reload;
  logic [7:0]            r_count;
  logic                  r_tf;
  logic                  r_tmr_out;
  logic [PRESCALE_W-1:0] r_presc;

  logic                  w_wr;
  logic                  w_wr_ctrl;
  logic                  w_wr_reload;
  logic                  w_wr_count;
  logic                  w_wr_status;
  logic [PRESCALE_W-1:0] w_div_m1;
  logic                  w_presc_tc;
  logic                  w_tick;
  logic                  w_uf;

  assign w_wr        = chip_select & write_enable;
  assign w_wr_ctrl   = w_wr & (addr_sel == ADDR_CTRL);
  assign w_wr_reload = w_wr & (addr_sel == ADDR_RELOAD);
  assign w_wr_count  = w_wr & (addr_sel == ADDR_COUNT);
  assign w_wr_status = w_wr & (addr_sel == ADDR_STATUS);

  always_comb begin
    case (r_psel)
      2'b00:   w_div_m1 = PRESCALE_W'(0);
      2'b01:   w_div_m1 = PRESCALE_W'(3);
      2'b10:   w_div_m1 = PRESCALE_W'(15);
      default: w_div_m1 = PRESCALE_W'(63);
    endcase
  end

  // A COUNT write on a tick cycle takes priority, so the tick is swallowed.
  assign w_presc_tc = (r_presc == w_div_m1);
  assign w_tick     = r_en & w_presc_tc & ~w_wr_count;
  assign w_uf       = w_tick & (r_count == 8'h00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_wr_ctrl || w_wr_count || !r_en || w_presc_tc) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 8'h00;
    end else if (w_wr_count) begin
      r_count <= data_in;
    end else if (w_tick) begin
      if (r_count != 8'h00) begin
        r_count <= r_count - 8'h01;
      end else if (r_auto) begin
        r_count <= r_reload;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_irq_en <= 1'b0;
      r_psel   <= 2'b00;
    end else if (w_wr_ctrl) begin
      r_en     <= data_in[0];
      r_auto   <= data_in[1];
      r_irq_en <= data_in[2];
      r_psel   <= data_in[5:4];
    end else if (w_uf && !r_auto) begin
      r_en     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reload <= 8'h00;
    end else if (w_wr_reload) begin
      r_reload <= data_in;
    end
  end

  // Underflow set beats a simultaneous write-one-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tf      <= 1'b0;
      r_tmr_out <= 1'b0;
    end else if (w_uf) begin
      r_tf      <= 1'b1;
      r_tmr_out <= ~r_tmr_out;
    end else if (w_wr_status && data_in[0]) begin
      r_tf      <= 1'b0;
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (chip_select && !write_enable) begin
      case (addr_sel)
        ADDR_CTRL:   data_out = {2'b00, r_psel, 1'b0, r_irq_en, r_auto, r_en};
        ADDR_RELOAD: data_out = r_reload;
        ADDR_COUNT:  data_out = r_count;
        default:     data_out = {6'b000000, r_en, r_tf};
      endcase
    end
  end

  assign irq     = r_tf & r_irq_en;
  assign tmr_out = r_tmr_out;

endmodule

// File: tb/tb_timer_8bit.sv
// Self-checking bench for timer_8bit: register table, directed corner
// sequences, then random bus traffic against a behavioural model.
module tb_timer_8bit;

  logic       clk;
  logic       reset;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] data_out;
  logic       irq;
  logic       tmr_out;

  int n_checks = 0;
  int n_errors = 0;

  timer_8bit #(.PRESCALE_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .chip_select  (cs),
    .write_enable (we),
    .addr_sel     (addr),
    .data_in      (din),
    .data_out     (data_out),
    .irq          (irq),
    .tmr_out      (tmr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Behavioural model: timer state in plain integers, divisor as a power of 4.
  bit       m_en, m_auto, m_irq_en, m_tf, m_tmr;
  int       m_psel, m_pcnt, m_count, m_reload;

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_irq_en = 0; m_tf = 0; m_tmr = 0;
    m_psel = 0; m_pcnt = 0; m_count = 0; m_reload = 0;
  endtask

  task automatic model_step();
    bit wr, tick, uf, wcount;
    int div;
    wr     = cs && we;
    div    = 1 << (2 * m_psel);
    wcount = wr && (addr == 2'd2);
    tick   = m_en && (m_pcnt == div - 1) && !wcount;
    uf     = tick && (m_count == 0);
    if (wcount) m_count = int'(din);
    else if (tick) begin
      if (m_count > 0) m_count = m_count - 1;
      else if (m_auto) m_count = m_reload;
    end
    if ((wr && (addr == 2'd0 || addr == 2'd2)) || !m_en) m_pcnt = 0;
    else m_pcnt = (m_pcnt + 1) % div;
    if (uf) begin
      m_tf  = 1;
      m_tmr = !m_tmr;
      if (!m_auto) m_en = 0;
    end else if (wr && addr == 2'd3 && din[0]) m_tf = 0;
    if (wr && addr == 2'd1) m_reload = int'(din);
    if (wr && addr == 2'd0) begin
      m_en = din[0]; m_auto = din[1]; m_irq_en = din[2]; m_psel = int'(din[5:4]);
    end
  endtask

  function automatic int model_read(input int a);
    case (a)
      0:       return (m_psel << 4) | (int'(m_irq_en) << 2) | (int'(m_auto) << 1) | int'(m_en);
      1:       return m_reload;
      2:       return m_count;
      default: return (int'(m_en) << 1) | int'(m_tf);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    step();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    cs = 1'b1; we = 1'b0; addr = a;
    #1;
    v  = data_out;
    cs = 1'b0;
  endtask

  typedef struct {
    bit         is_wr;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [7:0] v;
    int         k;
    bit         t_prev;

    vecs[0]  = '{0, 2'd0, 8'h00, 8'h00};
    vecs[1]  = '{0, 2'd1, 8'h00, 8'h00};
    vecs[2]  = '{0, 2'd2, 8'h00, 8'h00};
    vecs[3]  = '{0, 2'd3, 8'h00, 8'h00};
    vecs[4]  = '{1, 2'd0, 8'hFE, 8'h00};
    vecs[5]  = '{0, 2'd0, 8'h00, 8'h36};
    vecs[6]  = '{1, 2'd1, 8'hA5, 8'h00};
    vecs[7]  = '{0, 2'd1, 8'h00, 8'hA5};
    vecs[8]  = '{1, 2'd2, 8'h7E, 8'h00};
    vecs[9]  = '{0, 2'd2, 8'h00, 8'h7E};
    vecs[10] = '{0, 2'd3, 8'h00, 8'h00};
    vecs[11] = '{1, 2'd0, 8'h00, 8'h00};
    vecs[12] = '{0, 2'd0, 8'h00, 8'h00};
    vecs[13] = '{0, 2'd2, 8'h00, 8'h7E};

    cs = 0; we = 0; addr = 0; din = 0;
    reset = 1'b0;
    model_reset();
    #23;
    reset = 1'b1;
    idle(2);

    chk("reset_irq", int'(irq), 0);
    chk("reset_tmr_out", int'(tmr_out), 0);
    cs = 0; we = 0; addr = 2'd1; #1;
    chk("no_cs_data_out", int'(data_out), 0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].a, vecs[i].d);
      else begin
        rd(vecs[i].a, v);
        chk($sformatf("table_%0d_addr%0d", i, vecs[i].a), int'(v), int'(vecs[i].exp));
      end
    end

    // One-shot, divide by 1
    wr(2'd2, 8'd3);
    wr(2'd0, 8'h05);
    for (int e = 1; e <= 3; e++) begin
      idle(1);
      rd(2'd2, v);
      chk($sformatf("oneshot_count_edge%0d", e), int'(v), 3 - e);
    end
    idle(1);
    chk("oneshot_irq", int'(irq), 1);
    rd(2'd3, v); chk("oneshot_status", int'(v), 8'h01);
    chk("oneshot_tmr_out", int'(tmr_out), 1);
    idle(2);
    rd(2'd2, v); chk("oneshot_hold_zero", int'(v), 0);
    wr(2'd3, 8'h01);
    chk("oneshot_irq_cleared", int'(irq), 0);
    rd(2'd3, v); chk("oneshot_status_cleared", int'(v), 8'h00);

    // Auto-reload, divide by 4
    wr(2'd1, 8'd2);
    wr(2'd2, 8'd2);
    wr(2'd0, 8'h13);
    for (int u = 0; u < 2; u++) begin
      t_prev = tmr_out;
      k = 0;
      while (k <= 40) begin
        idle(1);
        k++;
        if (tmr_out != t_prev) break;
      end
      chk($sformatf("auto_period_%0d", u), k, 12);
      rd(2'd2, v); chk($sformatf("auto_reload_count_%0d", u), int'(v), 2);
    end
    idle(4);
    rd(2'd2, v); chk("auto_count_after_tick", int'(v), 1);
    rd(2'd3, v); chk("auto_status", int'(v), 8'h03);
    chk("auto_irq_masked", int'(irq), 0);

    // COUNT write on a tick cycle
    wr(2'd0, 8'h00);
    wr(2'd3, 8'h01);
    wr(2'd2, 8'd10);
    wr(2'd0, 8'h01);
    wr(2'd2, 8'd50);
    rd(2'd2, v); chk("collision_write_wins", int'(v), 50);
    idle(1);
    rd(2'd2, v); chk("collision_then_dec", int'(v), 49);
    wr(2'd0, 8'h00);

    // W1C in the exact underflow cycle
    wr(2'd2, 8'd1);
    wr(2'd0, 8'h01);
    idle(1);
    wr(2'd3, 8'h01);
    rd(2'd3, v); chk("tf_race_set_wins", int'(v), 8'h01);
    wr(2'd3, 8'h01);

    // CTRL write in a one-shot underflow cycle keeps EN
    wr(2'd2, 8'd0);
    wr(2'd0, 8'h01);
    wr(2'd0, 8'h01);
    rd(2'd3, v); chk("ctrl_vs_uf_en_wins", int'(v), 8'h03);
    idle(1);
    rd(2'd3, v); chk("ctrl_vs_uf_next_stop", int'(v), 8'h01);

    // Reset mid-operation
    wr(2'd3, 8'h01);
    wr(2'd1, 8'd0);
    wr(2'd2, 8'd0);
    wr(2'd0, 8'h07);
    idle(2);
    chk("pre_reset_irq", int'(irq), 1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_reset_irq", int'(irq), 0);
    chk("async_reset_tmr", int'(tmr_out), 0);
    rd(2'd0, v); chk("async_reset_ctrl", int'(v), 0);
    rd(2'd2, v); chk("async_reset_count", int'(v), 0);
    reset = 1'b1;
    idle(3);
    rd(2'd0, v); chk("post_reset_ctrl", int'(v), 0);
    rd(2'd1, v); chk("post_reset_reload", int'(v), 0);
    rd(2'd2, v); chk("post_reset_count", int'(v), 0);
    rd(2'd3, v); chk("post_reset_status", int'(v), 0);
    chk("post_reset_irq", int'(irq), 0);
    chk("post_reset_tmr", int'(tmr_out), 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int a = 0; a < 4; a++) begin
        rd(a[1:0], v);
        chk($sformatf("rand_c%0d_rd%0d", c, a), int'(v), model_read(a));
      end
      chk($sformatf("rand_c%0d_irq", c), int'(irq), int'(m_tf && m_irq_en));
      chk($sformatf("rand_c%0d_tmr", c), int'(tmr_out), int'(m_tmr));
      k = int'($urandom_range(0, 9));
      addr = 2'($urandom_range(0, 3));
      if (k < 5) begin
        cs = 0; we = 0; din = 8'($urandom);
      end else if (k == 5) begin
        cs = 0; we = 1; din = 8'($urandom);
      end else if (k == 6) begin
        cs = 1; we = 0; din = 8'($urandom);
      end else begin
        cs = 1; we = 1;
        if (addr == 2'd1 || addr == 2'd2) din = 8'($urandom_range(0, 6));
        else din = 8'($urandom);
      end
      step();
      cs = 0; we = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_8bit.md
Name: timer_8bit

Overview:
- Memory-mapped 8-bit down-counting timer.
- Bus responder on the VAA8-S1 system bus, in the same slot style as pio_8bit: the address decoder drives a chip select, the CPU drives the global write strobe, and read data returns through the system data mux.
- Provides periodic or one-shot timing, an interrupt request and a square-wave output pin.

Parameters:
- PRESCALE_W, 6, width of the free-running prescaler counter; must be at least 6 to support divide-by-64.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- chip_select  input  1  block selected by the address decoder.
- write_enable  input  1  global bus write strobe.
- addr_sel  input  2  register select, taken from address_bus[1:0].
- data_in  input  8  write data from the CPU.
- data_out  output  8  read data to the system data mux.
- irq  output  1  interrupt request, level.
- tmr_out  output  1  square-wave output; toggles on every underflow.

Behaviour:
- Register map (addr_sel):
  - 0 CTRL, R/W: bit0 EN, bit1 AUTO (auto-reload), bit2 IRQ_EN, bits[5:4] PSEL (00 ÷1, 01 ÷4, 10 ÷16, 11 ÷64). Bits 3, 6 and 7 read as 0.
  - 1 RELOAD, R/W.
  - 2 COUNT, read gives the live counter. A write loads the counter and clears the prescaler.
  - 3 STATUS, read gives bit0 TF (terminal flag), bit1 RUN (=EN), others 0. Writing 1 to bit0 clears TF; writing 0 has no effect.
- Writes: registered on the rising clk edge when chip_select=1 and write_enable=1.
- Reads:
  - data_out is combinational from the selected register when chip_select=1 and write_enable=0.
  - Otherwise data_out=8'h00.
  - Reads have no side effects.
- Reset (reset=0, asynchronous): CTRL=0, RELOAD=0, COUNT=0, TF=0, prescaler=0, tmr_out=0, irq=0.
- Prescaler:
  - Counts clk cycles only while EN=1.
  - Held at 0 while EN=0, and cleared on any CTRL or COUNT write.
  - Issues a one-cycle tick when it equals DIV-1 (DIV = 1, 4, 16 or 64), then wraps to 0.
  - For ÷1, every enabled cycle is a tick.
- State per tick (EN=1 only):
  - COUNT≠0: COUNT←COUNT-1.
  - COUNT=0 (underflow): TF←1 and tmr_out toggles.
    - AUTO=1: COUNT←RELOAD and EN stays 1.
    - AUTO=0: COUNT stays 0 and EN←0 (one-shot stops by itself).
- Period: RELOAD+1 ticks between underflows in auto mode. RELOAD=0 gives an underflow on every tick.
- Latency from enabling, with ÷1 and COUNT=N:
  - The CTRL write edge sets EN.
  - The N following edges decrement the counter.
  - Edge N+1 is the underflow; TF is visible after that edge.
- irq = TF & IRQ_EN, combinational from registers. It stays high until TF is cleared or IRQ_EN is cleared.
- Simultaneous events:
  - CPU write to COUNT in the same cycle as a tick: the write wins and no decrement occurs.
  - CPU write to CTRL in the same cycle as a one-shot underflow: the CTRL write value for EN wins. TF is still set.
  - TF set by underflow and W1C clear in the same cycle: the set wins and TF=1.
  - RELOAD written in the same cycle as an auto-reload: COUNT takes the old RELOAD value.
- PSEL change while running: the CTRL write clears the prescaler, so the new divisor starts from a full period.
- Reset mid-count: all state returns to reset values immediately (asynchronous), and irq drops without waiting for a clock.
- No wrap below 0: COUNT never reads 8'hFF as a result of counting; it only reloads or holds at 0.

Test Plan:
- Reset and reads: hold reset=0, then release. Reads of CTRL, RELOAD, COUNT and STATUS return 00. irq=0, tmr_out=0, and data_out=00 with chip_select=0.
- One-shot at ÷1:
  - Stimulus: COUNT←3, then CTRL←8'h05 (EN, IRQ_EN).
  - COUNT reads 2, 1, 0 after successive edges.
  - TF=1 and irq=1 after the 4th edge; STATUS reads 8'h01 (EN cleared).
  - tmr_out=1.
  - Writing STATUS←01 drops irq.
- Auto-reload with ÷4:
  - Stimulus: RELOAD←2, COUNT←2, CTRL←8'h13.
  - Underflows every 12 clk cycles.
  - tmr_out toggles each underflow (period 24 cycles); COUNT restarts at 2.
- Write collision: with ÷1 running at COUNT=10, write COUNT←50 on a tick cycle. The next cycle reads 50, then 49.
- TF set/clear race: issue the W1C to STATUS in the exact underflow cycle. TF reads 1 afterwards.
- Reset mid-operation: pull reset low while auto-mode is running with irq=1. irq, tmr_out and all registers go to 0 before the next clk edge, and stay 0 after reset is released until the timer is re-enabled.
